bias_relu_stage: RTL

- Post-processing stage directly downstream of the shift-multiply matrix multiplier.
- Once the multiplier's done rises, it reads every result word from the multiplier's output BRAM read port and reads the matching bias word.
- Per element: adds the bias, saturates, applies ReLU.
- Streams results one per cycle as the write stream for the next layer's multiplier input (its write-enable plus its data port).

---
 rtl/bias_relu_stage_pkg.sv | 20 ++
 rtl/bias_relu_stage_sat.sv | 34 +++
 rtl/bias_relu_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bias_relu_stage_pkg.sv
// Shared Q-format widths, saturation limits and the FSM encoding for the
// bias + ReLU post-processing stage.
package bias_relu_stage_pkg;

   localparam int INTEGER_WIDTH  = 10;
   localparam int FRACTION_WIDTH = 10;
   localparam int W              = INTEGER_WIDTH + FRACTION_WIDTH;
   localparam int ADDR_W         = 10;

   localparam logic [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

endpackage

// File: rtl/bias_relu_stage_sat.sv
// Combinational widen-add of two signed Q words, saturate back to W bits,
// then optionally clamp negatives to zero.
module fx_sat_add_relu
   import bias_relu_stage_pkg::*;
#(
   parameter int W          = bias_relu_stage_pkg::W,
   parameter bit APPLY_RELU = 1'b1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

   logic [W:0]   sum;
   logic [W-1:0] sat;

   always_comb begin
      sum = {a[W-1], a} + {b[W-1], b};
      // Top two bits disagree only when the W-bit result overflowed.
      if (sum[W] != sum[W-1]) begin
         sat = sum[W] ? SAT_MIN : SAT_MAX;
      end else begin
         sat = sum[W-1:0];
      end
      y = sat;
      if (APPLY_RELU && sat[W-1]) begin
         y = '0;
      end
   end

endmodule

// File: rtl/bias_relu_stage.sv
// Reads every upstream result word plus its bias after upstream done rises,
// applies saturating bias-add and ReLU, and streams results one per cycle.
module bias_relu_stage
   import bias_relu_stage_pkg::*;
#(
   parameter int NUM_OUTPUTS    = 3,
   parameter int integer_width  = INTEGER_WIDTH,
   parameter int fraction_width = FRACTION_WIDTH,
   parameter int READ_LATENCY   = 3,
   parameter bit APPLY_RELU     = 1'b1,
   localparam int DW            = integer_width + fraction_width
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] mm_address,
   output logic              mm_enable,
   input  logic [DW-1:0]     mm_data,
   output logic [ADDR_W-1:0] bias_address,
   input  logic [DW-1:0]     bias_data,
   output logic              out_valid,
   output logic [DW-1:0]     out_data,
   output logic              busy,
   output logic              done,
   output logic [1:0]        dbg_state
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_OUTPUTS - 1);

   state_e                  state_q, state_d;
   logic                    start_q, start_d;
   logic [ADDR_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic                    en_q, en_d;
   logic [READ_LATENCY-1:0] pipe_q, pipe_d;
   logic                    out_valid_q, out_valid_d;
   logic [DW-1:0]           out_data_q, out_data_d;
   logic [DW-1:0]           sat_y;
   logic                    launch;

   fx_sat_add_relu #(
      .W          (DW),
      .APPLY_RELU (APPLY_RELU)
   ) u_sat (
      .a (mm_data),
      .b (bias_data),
      .y (sat_y)
   );

   always_comb begin
      state_d     = state_q;
      start_d     = start;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      en_d        = 1'b0;
      launch      = start & ~start_q;

      case (state_q)
         ST_IDLE: begin
            if (launch) begin
               state_d = ST_ISSUE;
               cnt_d   = '0;
            end
         end
         ST_ISSUE: begin
            addr_d = cnt_q;
            en_d   = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Last read still in flight until both the enable and pipe clear.
            if (!en_q && (pipe_q == '0)) begin
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The pipe follows the registered enable so it lines up with the
      // cycle the address is actually presented to the memories.
      pipe_d[0] = en_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end

      out_valid_d = pipe_q[READ_LATENCY-1];
      out_data_d  = pipe_q[READ_LATENCY-1] ? sat_y : out_data_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         start_q     <= 1'b0;
         cnt_q       <= '0;
         addr_q      <= '0;
         en_q        <= 1'b0;
         pipe_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         en_q        <= en_d;
         pipe_q      <= pipe_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign mm_address   = addr_q;
   assign bias_address = addr_q;
   assign mm_enable    = en_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_FINISH);
   assign dbg_state    = state_q;

endmodule
